// File: rtl/instruction_mem_stage.sv
// MEM stage of the five-stage MIPS pipeline plus the MEM/WB register.
// Byte-addressed little-endian data memory with byte/half/word access and a read-only debug port.
module instruction_mem_stage #(
    parameter int MEM_DEPTH_WORDS = 64,
    localparam int AW = $clog2(MEM_DEPTH_WORDS) + 2
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_halt,
    input  logic          i_ctl_MEM_mem_read,
    input  logic          i_ctl_MEM_mem_write,
    input  logic [1:0]    i_ctl_MEM_width,
    input  logic          i_ctl_MEM_unsigned,
    input  logic          i_ctl_WB_mem_to_reg,
    input  logic          i_ctl_WB_reg_write,
    input  logic [31:0]   i_ALU_result,
    input  logic [31:0]   i_data_to_store,
    input  logic [4:0]    i_reg_dest,
    input  logic [AW-3:0] i_debug_addr,
    output logic [31:0]   o_debug_data,
    output logic [31:0]   o_ALU_result,
    output logic [31:0]   o_data_from_memory,
    output logic [4:0]    o_reg_dest,
    output logic          o_ctl_WB_mem_to_reg_WB,
    output logic          o_ctl_WB_reg_write_WB,
    output logic          o_misaligned
);

    logic [31:0]   mem [MEM_DEPTH_WORDS];

    logic [AW-1:0] addr;
    logic [AW-3:0] word_idx;
    logic [31:0]   rd_word;
    logic [31:0]   lane_shift;
    logic [15:0]   half_sel;
    logic          align_err;
    logic          access_mis;
    logic [3:0]    byte_en;
    logic [31:0]   wr_word;
    logic [31:0]   load_ext;
    logic [31:0]   load_data;
    logic          store_ok;

    assign addr         = i_ALU_result[AW-1:0];
    assign word_idx     = addr[AW-1:2];
    assign rd_word      = mem[word_idx];
    assign o_debug_data = mem[i_debug_addr];

    always_comb begin
        align_err  = 1'b0;
        byte_en    = 4'b1111;
        wr_word    = i_data_to_store;
        load_ext   = rd_word;
        lane_shift = rd_word >> {addr[1:0], 3'b000};
        half_sel   = addr[1] ? rd_word[31:16] : rd_word[15:0];

        case (i_ctl_MEM_width)
            2'b00: begin
                byte_en  = 4'b0001 << addr[1:0];
                wr_word  = {4{i_data_to_store[7:0]}};
                load_ext = i_ctl_MEM_unsigned ? {24'b0, lane_shift[7:0]}
                                              : {{24{lane_shift[7]}}, lane_shift[7:0]};
            end
            2'b01: begin
                align_err = addr[0];
                byte_en   = addr[1] ? 4'b1100 : 4'b0011;
                wr_word   = {2{i_data_to_store[15:0]}};
                load_ext  = i_ctl_MEM_unsigned ? {16'b0, half_sel}
                                               : {{16{half_sel[15]}}, half_sel};
            end
            // 2'b10 is decoded as a word access
            default: begin
                align_err = (addr[1:0] != 2'b00);
            end
        endcase

        access_mis = (i_ctl_MEM_mem_read | i_ctl_MEM_mem_write) & align_err;
        load_data  = (i_ctl_MEM_mem_read && !align_err) ? load_ext : 32'b0;
        store_ok   = i_ctl_MEM_mem_write && !align_err && !i_halt;
    end

    // Memory write: the load above already sampled the pre-store word.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int w = 0; w < MEM_DEPTH_WORDS; w++) begin
                mem[w] <= 32'b0;
            end
        end else if (store_ok) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[word_idx][b*8 +: 8] <= wr_word[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_ALU_result           <= 32'b0;
            o_data_from_memory     <= 32'b0;
            o_reg_dest             <= 5'b0;
            o_ctl_WB_mem_to_reg_WB <= 1'b0;
            o_ctl_WB_reg_write_WB  <= 1'b0;
            o_misaligned           <= 1'b0;
        end else if (!i_halt) begin
            o_ALU_result           <= i_ALU_result;
            o_data_from_memory     <= load_data;
            o_reg_dest             <= i_reg_dest;
            o_ctl_WB_mem_to_reg_WB <= i_ctl_WB_mem_to_reg;
            o_ctl_WB_reg_write_WB  <= i_ctl_WB_reg_write & ~(i_ctl_MEM_mem_read & align_err);
            o_misaligned           <= access_mis;
        end
    end

endmodule

// File: tb/tb_instruction_mem_stage.sv
// Directed bench for instruction_mem_stage: a vector table in program order plus
// hand-written halt and mid-stream reset sequences.
module tb_instruction_mem_stage;

    logic        clk = 1'b0;
    logic        rst, halt, rd, wr, uns, m2r, rw;
    logic [1:0]  width;
    logic [31:0] alu, wdata;
    logic [4:0]  dest;
    logic [5:0]  dbg_addr;
    logic [31:0] dbg_data, o_alu, o_data;
    logic [4:0]  o_dest;
    logic        o_m2r, o_rw, o_mis;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    instruction_mem_stage #(.MEM_DEPTH_WORDS(64)) dut (
        .i_clk                  (clk),
        .i_reset                (rst),
        .i_halt                 (halt),
        .i_ctl_MEM_mem_read     (rd),
        .i_ctl_MEM_mem_write    (wr),
        .i_ctl_MEM_width        (width),
        .i_ctl_MEM_unsigned     (uns),
        .i_ctl_WB_mem_to_reg    (m2r),
        .i_ctl_WB_reg_write     (rw),
        .i_ALU_result           (alu),
        .i_data_to_store        (wdata),
        .i_reg_dest             (dest),
        .i_debug_addr           (dbg_addr),
        .o_debug_data           (dbg_data),
        .o_ALU_result           (o_alu),
        .o_data_from_memory     (o_data),
        .o_reg_dest             (o_dest),
        .o_ctl_WB_mem_to_reg_WB (o_m2r),
        .o_ctl_WB_reg_write_WB  (o_rw),
        .o_misaligned           (o_mis)
    );

    typedef struct {
        logic        rst, halt, rd, wr;
        logic [1:0]  width;
        logic        uns, m2r, rw;
        logic [31:0] alu, wdata;
        logic [4:0]  dest;
        logic [5:0]  dbg;
        logic [31:0] e_alu, e_data;
        logic [4:0]  e_dest;
        logic        e_m2r, e_rw, e_mis;
        logic [31:0] e_dbg;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, h, rdv, wrv, input logic [1:0] wd, input logic u, mr, rwv,
                       input logic [31:0] a, d, input logic [4:0] ds, input logic [5:0] dbg,
                       input logic [31:0] ea, ed, input logic [4:0] eds,
                       input logic em, erw, emis, input logic [31:0] edbg);
        vec_t v;
        v.rst = r; v.halt = h; v.rd = rdv; v.wr = wrv; v.width = wd; v.uns = u;
        v.m2r = mr; v.rw = rwv; v.alu = a; v.wdata = d; v.dest = ds; v.dbg = dbg;
        v.e_alu = ea; v.e_data = ed; v.e_dest = eds; v.e_m2r = em; v.e_rw = erw;
        v.e_mis = emis; v.e_dbg = edbg;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic drive(input logic r, h, rdv, wrv, input logic [1:0] wd, input logic u, mr, rwv,
                         input logic [31:0] a, d, input logic [4:0] ds, input logic [5:0] dbg);
        rst = r; halt = h; rd = rdv; wr = wrv; width = wd; uns = u;
        m2r = mr; rw = rwv; alu = a; wdata = d; dest = ds; dbg_addr = dbg;
    endtask

    task automatic chk_regs(input string tag, input logic [31:0] ea, ed, input logic [4:0] eds,
                            input logic em, erw, emis);
        chk({tag, " alu"},  o_alu,  ea);
        chk({tag, " data"}, o_data, ed);
        chk({tag, " dest"}, {27'b0, o_dest}, {27'b0, eds});
        chk({tag, " m2r"},  {31'b0, o_m2r}, {31'b0, em});
        chk({tag, " rw"},   {31'b0, o_rw},  {31'b0, erw});
        chk({tag, " mis"},  {31'b0, o_mis}, {31'b0, emis});
    endtask

    initial begin
        //   rst h rd wr w u m2r rw  alu           wdata         dest dbg |  e_alu         e_data        edst m2r rw mis e_dbg
        add(1,0,0,0,2'd3,0,0,0, 32'h0,        32'h0,        0, 4,   32'h0,        32'h0,        0, 0,0,0, 32'h0);
        add(0,0,0,1,2'd3,0,0,0, 32'h10,       32'hDEADBEEF, 0, 4,   32'h10,       32'h0,        0, 0,0,0, 32'hDEADBEEF);
        add(0,0,1,0,2'd3,0,1,1, 32'h10,       32'h0,        5, 4,   32'h10,       32'hDEADBEEF, 5, 1,1,0, 32'hDEADBEEF);
        add(0,0,0,1,2'd3,0,0,0, 32'h10,       32'h11223344, 0, 4,   32'h10,       32'h0,        0, 0,0,0, 32'h11223344);
        add(0,0,0,1,2'd0,0,0,0, 32'h13,       32'hFFFFFF80, 0, 4,   32'h13,       32'h0,        0, 0,0,0, 32'h80223344);
        add(0,0,1,0,2'd0,0,1,1, 32'h13,       32'h0,        7, 4,   32'h13,       32'hFFFFFF80, 7, 1,1,0, 32'h80223344);
        add(0,0,1,0,2'd0,1,1,1, 32'h13,       32'h0,        7, 4,   32'h13,       32'h00000080, 7, 1,1,0, 32'h80223344);
        add(0,0,1,0,2'd1,0,1,1, 32'h12,       32'h0,        7, 4,   32'h12,       32'hFFFF8022, 7, 1,1,0, 32'h80223344);
        add(0,0,1,0,2'd1,1,1,1, 32'h10,       32'h0,        8, 4,   32'h10,       32'h00003344, 8, 1,1,0, 32'h80223344);
        add(0,0,1,0,2'd0,0,1,1, 32'h11,       32'h0,        8, 4,   32'h11,       32'h00000033, 8, 1,1,0, 32'h80223344);
        add(0,0,1,0,2'd1,0,1,1, 32'h10,       32'h0,        8, 4,   32'h10,       32'h00003344, 8, 1,1,0, 32'h80223344);
        add(0,0,0,1,2'd3,0,0,0, 32'h20,       32'h12345678, 0, 8,   32'h20,       32'h0,        0, 0,0,0, 32'h12345678);
        add(0,0,0,1,2'd1,0,0,1, 32'h21,       32'h0000BEEF, 0, 8,   32'h21,       32'h0,        0, 0,1,1, 32'h12345678);
        add(0,0,1,0,2'd3,0,1,1, 32'h22,       32'h0,        9, 8,   32'h22,       32'h0,        9, 1,0,1, 32'h12345678);
        add(0,0,0,1,2'd1,0,0,0, 32'h22,       32'h0000ABCD, 0, 8,   32'h22,       32'h0,        0, 0,0,0, 32'hABCD5678);
        add(0,0,1,0,2'd2,0,1,1, 32'h20,       32'h0,        9, 8,   32'h20,       32'hABCD5678, 9, 1,1,0, 32'hABCD5678);
        add(0,0,1,0,2'd2,0,1,1, 32'h21,       32'h0,        9, 8,   32'h21,       32'h0,        9, 1,0,1, 32'hABCD5678);
        add(0,0,0,1,2'd0,0,0,0, 32'h21,       32'h00000099, 0, 8,   32'h21,       32'h0,        0, 0,0,0, 32'hABCD9978);
        add(0,0,0,1,2'd3,0,0,0, 32'h100,      32'hCAFE0001, 0, 0,   32'h100,      32'h0,        0, 0,0,0, 32'hCAFE0001);
        add(0,0,1,1,2'd3,0,1,1, 32'h0,        32'h00000001, 2, 0,   32'h0,        32'hCAFE0001, 2, 1,1,0, 32'h00000001);
        add(0,0,1,0,2'd3,0,1,1, 32'h0,        32'h0,        2, 0,   32'h0,        32'h00000001, 2, 1,1,0, 32'h00000001);
        add(0,0,0,0,2'd3,0,0,1, 32'h12345,    32'h0,        3, 0,   32'h12345,    32'h0,        3, 0,1,0, 32'h00000001);
        add(0,0,0,1,2'd3,0,0,0, 32'h30,       32'h01020304, 0, 12,  32'h30,       32'h0,        0, 0,0,0, 32'h01020304);
        add(0,0,0,0,2'd3,0,0,1, 32'hABCD0000, 32'h0,        1, 12,  32'hABCD0000, 32'h0,        1, 0,1,0, 32'h01020304);

        drive(1,0,0,0,2'd3,0,0,0, 32'h0, 32'h0, 0, 0);
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].halt, vecs[i].rd, vecs[i].wr, vecs[i].width, vecs[i].uns,
                  vecs[i].m2r, vecs[i].rw, vecs[i].alu, vecs[i].wdata, vecs[i].dest, vecs[i].dbg);
            @(posedge clk); #1;
            chk_regs($sformatf("v%0d", i), vecs[i].e_alu, vecs[i].e_data, vecs[i].e_dest,
                     vecs[i].e_m2r, vecs[i].e_rw, vecs[i].e_mis);
            chk($sformatf("v%0d dbg", i), dbg_data, vecs[i].e_dbg);
        end

        // Halt: byte store of 0x55 at 0x30 held off for three edges, outputs frozen.
        for (int c = 0; c < 3; c++) begin
            drive(0,1,0,1,2'd0,0,1,1, 32'h30, 32'h00000055, 12, 12);
            @(posedge clk); #1;
            chk_regs($sformatf("halt%0d", c), 32'hABCD0000, 32'h0, 1, 0, 1, 0);
            chk($sformatf("halt%0d dbg", c), dbg_data, 32'h01020304);
        end
        dbg_addr = 6'd4; #1;
        chk("halt dbg comb", dbg_data, 32'h80223344);
        dbg_addr = 6'd12;
        halt = 1'b0;
        @(posedge clk); #1;
        chk_regs("unhalt", 32'h30, 32'h0, 12, 1, 1, 0);
        chk("unhalt dbg", dbg_data, 32'h01020355);

        // Reset wins over halt and over the store presented in the same cycle.
        drive(1,1,1,1,2'd3,0,1,1, 32'h40, 32'hAAAA5555, 4, 16);
        @(posedge clk); #1;
        chk_regs("rst", 32'h0, 32'h0, 0, 0, 0, 0);
        chk("rst dbg16", dbg_data, 32'h0);
        dbg_addr = 6'd0; #1;
        chk("rst dbg0", dbg_data, 32'h0);
        dbg_addr = 6'd12; #1;
        chk("rst dbg12", dbg_data, 32'h0);
        drive(0,0,1,0,2'd3,0,1,1, 32'h40, 32'h0, 6, 16);
        @(posedge clk); #1;
        chk_regs("post_rst", 32'h40, 32'h0, 6, 1, 1, 0);
        chk("post_rst dbg16", dbg_data, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instruction_mem_stage.md
# instruction_mem_stage

Memory-access (MEM) stage of the five-stage MIPS pipeline, including the MEM/WB pipeline register. It takes the EX/MEM results and performs byte, halfword and word loads and stores against an internal byte-addressed data memory. It registers everything write-back needs: ALU result, load data, destination register and WB control. It also gives the debug unit a read-only port into data memory.

## Interface
- MEM_DEPTH_WORDS, 64, data memory depth in 32-bit words; power of two; address width AW = log2(MEM_DEPTH_WORDS)+2 byte bits
- i_clk  in  1  rising-edge clock
- i_reset  in  1  reset i_reset, synchronous, active-high
- i_halt  in  1  pipeline freeze
- i_ctl_MEM_mem_read  in  1  load enable
- i_ctl_MEM_mem_write  in  1  store enable
- i_ctl_MEM_width  in  2  access size: 00 byte, 01 half, 11 word; 10 is treated as word
- i_ctl_MEM_unsigned  in  1  1 = zero-extend loads, 0 = sign-extend loads
- i_ctl_WB_mem_to_reg  in  1  WB select, passed through (1 = memory data)
- i_ctl_WB_reg_write  in  1  WB register-write enable, passed through
- i_ALU_result  in  32  effective address / ALU value
- i_data_to_store  in  32  store data (rt); low bits used for byte/half
- i_reg_dest  in  5  destination register
- i_debug_addr  in  AW-2  debug word address
- o_debug_data  out  32  memory word at i_debug_addr, combinational
- o_ALU_result  out  32  registered i_ALU_result
- o_data_from_memory  out  32  registered, extended load data
- o_reg_dest  out  5  registered i_reg_dest
- o_ctl_WB_mem_to_reg_WB  out  1  registered WB control
- o_ctl_WB_reg_write_WB  out  1  registered WB control; forced 0 on a misaligned load
- o_misaligned  out  1  registered; 1 = the access captured this cycle was misaligned

## Operation
- Address: byte address = i_ALU_result[AW-1:0]. Upper bits are ignored, so addresses wrap modulo memory size. Word index = addr[AW-1:2]. Byte order is little-endian.
- Alignment: a half access with addr[0]=1 is misaligned; a word access with addr[1:0]≠0 is misaligned. Byte accesses are never misaligned.
- Store (mem_write=1, aligned, i_halt=0):
  - byte: writes lane addr[1:0] with data[7:0]
  - half: writes lanes {addr[1],1} and {addr[1],0} with data[15:0]
  - word: writes all lanes
  - Other lanes are untouched. A misaligned store writes nothing.
- Load: reads the addressed word before any same-cycle store takes effect.
  - byte: selects lane addr[1:0]
  - half: selects the halfword at addr[1]
  - word: full word
  - The result is sign- or zero-extended per i_ctl_MEM_unsigned. A misaligned load returns 0.
- Both mem_read and mem_write set: the store is performed, and the load returns the pre-store contents.
- mem_read=0: o_data_from_memory is loaded with 0.
- MEM/WB register, on each edge with i_halt=0: captures ALU result, load data, reg_dest, WB controls and the misaligned flag. o_ctl_WB_reg_write_WB = i_ctl_WB_reg_write & ~(mem_read & misaligned).
- Halt: with i_halt=1, all registered outputs hold their values and stores are suppressed. The debug port keeps working.
- Reset (edge with i_reset=1): all registered outputs go to 0 and every memory word goes to 0. Reset overrides both halt and any store in that cycle.

## Timing
- Inputs are sampled on the rising edge. Registered outputs are valid one cycle later, so EX/MEM → WB latency is 1 cycle.
- A store is visible to a load issued in the next cycle, and to o_debug_data immediately after the write edge.
- o_debug_data is combinational from i_debug_addr and the current memory contents, with zero latency.
- Reset values: o_ALU_result=0, o_data_from_memory=0, o_reg_dest=0, o_ctl_WB_mem_to_reg_WB=0, o_ctl_WB_reg_write_WB=0, o_misaligned=0.
- When i_halt deasserts, the next edge captures the inputs present on that edge. No stale transaction is replayed.
- Reset asserted mid-stream: the store in that cycle is dropped. From the next cycle, memory reads as 0.

## Test plan
- Word round-trip: store word 0xDEADBEEF at 0x10, then load word at 0x10 → o_data_from_memory=0xDEADBEEF, o_ctl_WB_reg_write_WB follows input, o_debug_data at word 4 = 0xDEADBEEF.
- Byte lanes and extension:
  - Store byte 0x80 at 0x13 over word 0x11223344 → word reads 0x80223344.
  - Signed byte load at 0x13 → 0xFFFFFF80.
  - Unsigned byte load at 0x13 → 0x00000080.
  - Signed half load at 0x12 → 0xFFFF8022.
- Misalignment:
  - Half store at 0x21 → memory unchanged, o_misaligned=1.
  - Word load at 0x22 with reg_write=1 → o_data_from_memory=0, o_ctl_WB_reg_write_WB=0.
- Halt: hold i_halt=1 for 3 cycles while presenting a store of 0x55 at 0x30 and new ALU values → outputs frozen, word 12 unchanged. Deassert halt → the store happens and the new values are registered.
- Wrap and simultaneous access (MEM_DEPTH_WORDS=64):
  - Store word 0xCAFE0001 at 0x100 → lands in word 0.
  - Read and write word 0 in the same cycle with new data 0x1 → load returns 0xCAFE0001, and the next load returns 0x1.
- Reset mid-operation: assert i_reset during a store of 0xAAAA5555 at 0x40 → all outputs 0, word 16 reads 0 after reset, nothing written.
